// File: rtl/instruction_prefetch_unit_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents: address/instruction widths, PC increment, fetch_entry_t,
// and a PC word-alignment helper.
package core_pkg;

   localparam int ADDR_WIDTH  = 32;
   localparam int INSTR_WIDTH = 32;

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   // One instruction-queue entry: the fetched word and the address it came from.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0]  pc;
      logic [INSTR_WIDTH-1:0] instr;
   } fetch_entry_t;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] a);
      return {a[ADDR_WIDTH-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_prefetch_unit_fifo.sv
// Generic synchronous FIFO with flush; storage is a register array.
// Latency: a push is visible at o_head the cycle after it is written.
// Backpressure: none internally; push while full (without pop) and pop while empty are ignored.
//
// Ports: clk, rst (sync, active-low), i_push/i_push_dat, i_pop, i_flush,
//        o_full, o_empty, o_count (occupancy), o_head (oldest entry).
module ifu_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_push_dat,
   input  logic                       i_pop,
   input  logic                       i_flush,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic [WIDTH-1:0]           o_head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   // Index plus one wrap bit; equal index with differing wrap bits means full.
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Explicit wrap so non-power-of-two depths also work.
   function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
      if (p[AW-1:0] == LAST_IDX) begin
         return {~p[AW], {AW{1'b0}}};
      end
      return {p[AW], p[AW-1:0] + AW'(1)};
   endfunction

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_comb begin
      o_count = '0;
      if (r_wr_ptr[AW] == r_rd_ptr[AW]) begin
         o_count = CW'(r_wr_ptr[AW-1:0]) - CW'(r_rd_ptr[AW-1:0]);
      end else begin
         o_count = CW'(DEPTH) - CW'(r_rd_ptr[AW-1:0]) + CW'(r_wr_ptr[AW-1:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
      end
   end

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Prefetching fetch unit: issues AR reads ahead, queues {pc, instr} for decode.
// Latency: RVALID in cycle N gives instr_valid in N+1 (N with IFU_BYPASS_EN and an empty queue).
// Backpressure: issue is credit-limited so the queue never overflows; RREADY is always high out of reset.
//
// Ports: clk, rst (sync, active-low); pc_write/pc_write_en and redirect_pc/redirect_valid
// restart fetch; ARADDR/ARVALID/ARREADY and RDATA/RVALID/RREADY form the memory port;
// instr_data/instr_pc/instr_valid/instr_ready feed decode; pc_value is the next fetch address.
// Optional macro IFU_BYPASS_EN: forward a response straight to decode when the queue is empty.
module instruction_prefetch_unit
   import core_pkg::*;
#(
   parameter int                    FIFO_DEPTH      = 4,
   parameter int                    MAX_OUTSTANDING = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  pc_write,
   input  logic                   pc_write_en,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc,
   input  logic                   redirect_valid,
   output logic [ADDR_WIDTH-1:0]  ARADDR,
   output logic                   ARVALID,
   input  logic                   ARREADY,
   input  logic [INSTR_WIDTH-1:0] RDATA,
   input  logic                   RVALID,
   output logic                   RREADY,
   output logic [INSTR_WIDTH-1:0] instr_data,
   output logic [ADDR_WIDTH-1:0]  instr_pc,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [ADDR_WIDTH-1:0]  pc_value
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = CW + 1;
   localparam logic [OW-1:0] MAX_O   = OW'(MAX_OUTSTANDING);
   localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);

   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic                  r_arvalid;
   logic                  r_rready;
   logic [OW-1:0]         r_outstanding;
   logic [OW-1:0]         r_discard;
   // Set when a redirect overtakes a pending, not yet accepted request.
   logic                  r_stale_ar;

   logic                  w_ar_hs;
   logic                  w_r_hs;
   logic                  w_redir;
   logic [ADDR_WIDTH-1:0] w_target;
   logic                  w_keep;
   logic                  w_bypass;
   logic                  w_fifo_push;
   logic                  w_fifo_pop;
   logic                  w_fifo_empty;
   logic [CW-1:0]         w_fifo_count;
   logic [CW-1:0]         w_occ_nxt;
   logic [OW-1:0]         w_out_nxt;
   logic [ADDR_WIDTH-1:0] w_fetch_pc_nxt;
   logic                  w_issue;
   fetch_entry_t          w_push_entry;
   fetch_entry_t          w_head_entry;
   logic [ADDR_WIDTH-1:0] w_tag_head;
   logic                  w_unused_ifq_full;
   logic                  w_unused_tag_full;
   logic                  w_unused_tag_empty;
   logic [OW-1:0]         w_unused_tag_count;

   assign w_ar_hs  = r_arvalid && ARREADY;
   assign w_r_hs   = RVALID && r_rready;
   assign w_redir  = pc_write_en || redirect_valid;
   assign w_target = align_pc(pc_write_en ? pc_write : redirect_pc);

   // A response reaches decode only if it is not stale and no redirect is flushing this cycle.
   assign w_keep = w_r_hs && !w_redir && (r_discard == '0);

`ifdef IFU_BYPASS_EN
   assign w_bypass = w_keep && w_fifo_empty;
`else
   assign w_bypass = 1'b0;
`endif

   assign instr_valid = !w_fifo_empty || w_bypass;
   assign w_fifo_pop  = instr_valid && instr_ready && !w_fifo_empty;
   // A bypassed entry taken by decode in the same cycle never enters the queue.
   assign w_fifo_push = w_keep && !(w_bypass && instr_ready);

   always_comb begin
      w_push_entry       = '0;
      w_push_entry.pc    = w_tag_head;
      w_push_entry.instr = RDATA;
   end

   always_comb begin
      instr_data = '0;
      instr_pc   = '0;
      if (!w_fifo_empty) begin
         instr_data = w_head_entry.instr;
         instr_pc   = w_head_entry.pc;
      end else if (w_bypass) begin
         instr_data = RDATA;
         instr_pc   = w_tag_head;
      end
   end

   // A stale request accepted after a redirect carries the old address, so it must not advance fetch.
   assign w_fetch_pc_nxt = w_redir                    ? w_target :
                           (w_ar_hs && !r_stale_ar)   ? r_fetch_pc + PC_STEP :
                                                        r_fetch_pc;

   assign w_out_nxt = r_outstanding + OW'(w_ar_hs) - OW'(w_r_hs);
   assign w_occ_nxt = w_redir ? '0 : w_fifo_count + CW'(w_fifo_push) - CW'(w_fifo_pop);

   // Credits are judged on next-cycle state, which lets a new request follow an accepted one
   // back-to-back; a pending unaccepted request is never re-evaluated or withdrawn.
   assign w_issue = (!r_arvalid || w_ar_hs) &&
                    (w_out_nxt < MAX_O) &&
                    ((SW'(w_out_nxt) + SW'(w_occ_nxt)) < DEPTH_S);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fetch_pc    <= RESET_PC;
         r_araddr      <= RESET_PC;
         r_arvalid     <= 1'b0;
         r_rready      <= 1'b0;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_stale_ar    <= 1'b0;
      end else begin
         r_rready      <= 1'b1;
         r_fetch_pc    <= w_fetch_pc_nxt;
         r_outstanding <= w_out_nxt;

         if (w_redir) begin
            // Everything still in flight after this edge belongs to the old path.
            r_discard  <= w_out_nxt;
            r_stale_ar <= r_arvalid && !ARREADY;
         end else begin
            r_discard <= r_discard - OW'(w_r_hs && (r_discard != '0))
                                   + OW'(w_ar_hs && r_stale_ar);
            if (w_ar_hs) r_stale_ar <= 1'b0;
         end

         if (w_issue) begin
            r_arvalid <= 1'b1;
            r_araddr  <= w_fetch_pc_nxt;
         end else if (w_ar_hs) begin
            r_arvalid <= 1'b0;
         end
      end
   end

   assign ARADDR   = r_araddr;
   assign ARVALID  = r_arvalid;
   assign RREADY   = r_rready;
   assign pc_value = r_fetch_pc;

   ifu_sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_instr_q (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_fifo_push),
      .i_push_dat (w_push_entry),
      .i_pop      (w_fifo_pop),
      .i_flush    (w_redir),
      .o_full     (w_unused_ifq_full),
      .o_empty    (w_fifo_empty),
      .o_count    (w_fifo_count),
      .o_head     (w_head_entry)
   );

   // In-flight request addresses; responses return in order, so the head tags the current R beat.
   ifu_sync_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_q (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_ar_hs),
      .i_push_dat (r_araddr),
      .i_pop      (w_r_hs),
      .i_flush    (1'b0),
      .o_full     (w_unused_tag_full),
      .o_empty    (w_unused_tag_empty),
      .o_count    (w_unused_tag_count),
      .o_head     (w_tag_head)
   );

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Bench for instruction_prefetch_unit: single-cycle memory model that returns the address as data,
// a per-cycle vector table for streaming/backpressure, and hand sequences for redirect and reset.
module tb_instruction_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_write;
   logic        pc_write_en;
   logic [31:0] redirect_pc;
   logic        redirect_valid;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic        RVALID;
   logic        RREADY;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] pc_value;

   int errors = 0;
   int checks = 0;
   logic        mem_en;
   logic [31:0] mem_q[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_dat[$];

   typedef struct {
      logic        irdy;
      logic        arrdy;
      logic        exp_arv;
      logic [31:0] exp_addr;
      logic        exp_iv;
      logic [31:0] exp_ipc;
      logic [31:0] exp_pcv;
   } vec_t;

   vec_t tbl[16];

   instruction_prefetch_unit #(
      .FIFO_DEPTH      (4),
      .MAX_OUTSTANDING (2),
      .RESET_PC        (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_write       (pc_write),
      .pc_write_en    (pc_write_en),
      .redirect_pc    (redirect_pc),
      .redirect_valid (redirect_valid),
      .ARADDR         (ARADDR),
      .ARVALID        (ARVALID),
      .ARREADY        (ARREADY),
      .RDATA          (RDATA),
      .RVALID         (RVALID),
      .RREADY         (RREADY),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .pc_value       (pc_value)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic irdy, input logic arrdy, input logic arv,
                               input logic [31:0] addr, input logic iv,
                               input logic [31:0] ipc, input logic [31:0] pcv);
      vec_t v;
      v.irdy = irdy; v.arrdy = arrdy; v.exp_arv = arv; v.exp_addr = addr;
      v.exp_iv = iv; v.exp_ipc = ipc; v.exp_pcv = pcv;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // Sample handshakes just before the edge, advance one clock, then present the memory response.
   task automatic cycle();
      logic [31:0] dummy;
      if (RVALID && RREADY) dummy = mem_q.pop_front();
      if (ARVALID && ARREADY) mem_q.push_back(ARADDR);
      if (instr_valid && instr_ready) begin
         got_pc.push_back(instr_pc);
         got_dat.push_back(instr_data);
      end
      @(posedge clk);
      #1;
      if (!rst) mem_q.delete();
      RVALID = mem_en && (mem_q.size() != 0);
      RDATA  = RVALID ? mem_q[0] : 32'h0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      pc_write_en = 1'b0;
      redirect_valid = 1'b0;
      RVALID = 1'b0;
      RDATA = 32'h0;
      mem_q.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic chk_first(input string nm, input logic [31:0] exp);
      checks++;
      if (got_pc.size() == 0) begin
         errors++;
         $display("FAIL %s: got no output entry, expected pc 0x%08h", nm, exp);
      end else if (got_pc[0] !== exp || got_dat[0] !== exp) begin
         errors++;
         $display("FAIL %s: got pc 0x%08h data 0x%08h, expected 0x%08h", nm, got_pc[0], got_dat[0], exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      pc_write = 32'h0; redirect_pc = 32'h0;
      mem_en = 1'b1; ARREADY = 1'b1; instr_ready = 1'b1;

      // Streaming, then decode stall until credits run out, then drain.
      tbl[0]  = mk(1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h00);
      tbl[1]  = mk(1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h04);
      tbl[2]  = mk(1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'h08);
      tbl[3]  = mk(1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h0C);
      tbl[4]  = mk(1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 32'h10);
      tbl[5]  = mk(1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 32'h14);
      tbl[6]  = mk(1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C, 32'h18);
      tbl[7]  = mk(1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C, 32'h1C);
      tbl[8]  = mk(1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C, 32'h1C);
      tbl[9]  = mk(1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C, 32'h1C);
      tbl[10] = mk(1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C, 32'h1C);
      tbl[11] = mk(1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 32'h1C);
      tbl[12] = mk(1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14, 32'h20);
      tbl[13] = mk(1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h18, 32'h24);
      tbl[14] = mk(1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h1C, 32'h28);
      tbl[15] = mk(1'b1, 1'b1, 1'b1, 32'h2C, 1'b1, 32'h20, 32'h2C);

      // Reset state.
      do_reset();
      chk("rst.arvalid", 32'(ARVALID), 32'h0);
      chk("rst.rready", 32'(RREADY), 32'h0);
      chk("rst.instr_valid", 32'(instr_valid), 32'h0);
      chk("rst.pc_value", pc_value, 32'h0);
      chk("rst.araddr", ARADDR, 32'h0);
      chk("rst.instr_pc", instr_pc, 32'h0);
      chk("rst.instr_data", instr_data, 32'h0);

      // Vector table.
      rst = 1'b1;
      cycle();
      chk("c0.rready", 32'(RREADY), 32'h1);
      for (int i = 0; i < 16; i++) begin
         instr_ready = tbl[i].irdy;
         ARREADY     = tbl[i].arrdy;
         chk($sformatf("tbl[%0d].arvalid", i), 32'(ARVALID), 32'(tbl[i].exp_arv));
         if (tbl[i].exp_arv) chk($sformatf("tbl[%0d].araddr", i), ARADDR, tbl[i].exp_addr);
         chk($sformatf("tbl[%0d].instr_valid", i), 32'(instr_valid), 32'(tbl[i].exp_iv));
         chk($sformatf("tbl[%0d].instr_pc", i), instr_pc, tbl[i].exp_ipc);
         chk($sformatf("tbl[%0d].instr_data", i), instr_data, tbl[i].exp_ipc);
         chk($sformatf("tbl[%0d].pc_value", i), pc_value, tbl[i].exp_pcv);
         cycle();
      end

      // Redirect with 0x10 and 0x14 in flight: both responses dropped, fetch resumes at 0x100.
      instr_ready = 1'b1; ARREADY = 1'b1; mem_en = 1'b1;
      do_reset();
      rst = 1'b1;
      cycle();
      repeat (4) cycle();
      mem_en = 1'b0;
      cycle();
      cycle();
      chk("rd1.arvalid_blocked", 32'(ARVALID), 32'h0);
      got_pc.delete(); got_dat.delete();
      redirect_valid = 1'b1; redirect_pc = 32'h103; mem_en = 1'b1;
      cycle();
      redirect_valid = 1'b0;
      chk("rd1.instr_valid_after", 32'(instr_valid), 32'h0);
      chk("rd1.pc_value", pc_value, 32'h100);
      repeat (6) cycle();
      chk_first("rd1.first_out", 32'h100);
      checks++;
      if (got_pc.size() < 2 || got_pc[1] !== 32'h104) begin
         errors++;
         $display("FAIL rd1.second_out: got %0d entries, expected second pc 0x00000104", got_pc.size());
      end

      // Redirect while a request is pending and not accepted.
      do_reset();
      rst = 1'b1;
      cycle();
      repeat (8) cycle();
      chk("rd2.pending_addr", ARADDR, 32'h20);
      ARREADY = 1'b0;
      cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      cycle();
      redirect_valid = 1'b0;
      chk("rd2.arvalid_held", 32'(ARVALID), 32'h1);
      chk("rd2.araddr_held", ARADDR, 32'h20);
      chk("rd2.pc_value", pc_value, 32'h200);
      chk("rd2.instr_valid_after", 32'(instr_valid), 32'h0);
      got_pc.delete(); got_dat.delete();
      ARREADY = 1'b1;
      cycle();
      chk("rd2.next_addr", ARADDR, 32'h200);
      chk("rd2.next_arvalid", 32'(ARVALID), 32'h1);
      repeat (4) cycle();
      chk_first("rd2.first_out", 32'h200);

      // pc_write wins over a simultaneous redirect.
      do_reset();
      rst = 1'b1;
      cycle();
      pc_write_en = 1'b1; pc_write = 32'h400;
      redirect_valid = 1'b1; redirect_pc = 32'h800;
      cycle();
      pc_write_en = 1'b0; redirect_valid = 1'b0;
      chk("pw.pc_value", pc_value, 32'h400);
      chk("pw.araddr", ARADDR, 32'h400);
      chk("pw.arvalid", 32'(ARVALID), 32'h1);
      got_pc.delete(); got_dat.delete();
      repeat (4) cycle();
      chk_first("pw.first_out", 32'h400);

      // Reset in the middle of a stream with entries buffered.
      do_reset();
      rst = 1'b1;
      cycle();
      instr_ready = 1'b0;
      repeat (6) cycle();
      chk("mr.buffered", 32'(instr_valid), 32'h1);
      rst = 1'b0;
      cycle();
      chk("mr.instr_valid", 32'(instr_valid), 32'h0);
      chk("mr.arvalid", 32'(ARVALID), 32'h0);
      chk("mr.rready", 32'(RREADY), 32'h0);
      chk("mr.pc_value", pc_value, 32'h0);
      chk("mr.araddr", ARADDR, 32'h0);
      chk("mr.instr_pc", instr_pc, 32'h0);
      rst = 1'b1; instr_ready = 1'b1;
      cycle();
      chk("mr.restart_arvalid", 32'(ARVALID), 32'h1);
      chk("mr.restart_araddr", ARADDR, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
